ysyx_24100005_mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter that shares the core's single data-memory port (DPI-backed) between the IFU (master 0) and the LSU (master 1).
- Serialises requests with one outstanding transaction at a time, using round-robin grant.
- Routes each response back to the owning master.
- A watchdog converts a hung slave into an error response.
- Sits between the fetch/load-store stages and the memory bridge in the multi-cycle core.

---
 rtl/ysyx_24100005_mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU (m0) and LSU (m1), one transaction at a time.
// Latency: slave sees the request 1 cycle after the master handshake; the response is forwarded combinationally.
// Backpressure: masters stall outside IDLE; the slave response is held until the owning master is ready; watchdog errors out a hung slave.
module ysyx_24100005_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_wen,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_wen,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int MASK_W = DATA_W / 8;

    // Watchdog fires on the cycle the counter reaches TIMEOUT-1; TIMEOUT==0 switches it off.
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    // S_ERR is the error-response mode: the slave is abandoned and the owner gets err=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                owner_q;
    logic                last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [TO_W-1:0]     to_cnt_q;

    logic                any_req;
    logic                grant;
    logic                accept;
    logic                owner_resp_ready;
    logic                complete;
    logic                in_flight;
    logic                wd_fire;
    logic [DATA_W-1:0]   rsp_data;

    // Grant and completion qualifiers shared by the FSM and the datapath.
    always_comb begin
        any_req          = m0_req_valid | m1_req_valid;
        // On a tie the master that did not win last time goes; otherwise whichever is asking.
        grant            = (m0_req_valid & m1_req_valid) ? ~last_grant_q : ~m0_req_valid;
        accept           = (state_q == S_IDLE) & any_req;
        owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;
        complete         = (state_q == S_DATA) & s_resp_valid & owner_resp_ready;
        in_flight        = (state_q == S_ADDR) | (state_q == S_DATA);
        // A response landing in the timeout cycle still counts as a normal completion.
        wd_fire          = WD_EN & in_flight & (to_cnt_q == TO_LAST) & ~complete;
        rsp_data         = wen_q ? {DATA_W{1'b0}} : s_rdata;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (wd_fire) begin
                    state_d = S_ERR;
                end else if (s_req_ready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (complete) begin
                    state_d = S_IDLE;
                end else if (wd_fire) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (owner_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, ownership and round-robin history, captured on the master handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else if (accept) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            addr_q       <= grant ? m1_addr  : m0_addr;
            wen_q        <= grant ? m1_wen   : m0_wen;
            wdata_q      <= grant ? m1_wdata : m0_wdata;
            wmask_q      <= grant ? m1_wmask : m0_wmask;
        end
    end

    // Watchdog counter: cleared on accept, counts saturating while the slave owns the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (accept) begin
            to_cnt_q <= '0;
        end else if (in_flight && (to_cnt_q != TO_MAX)) begin
            to_cnt_q <= to_cnt_q + TO_ONE;
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_rdata      = '0;
        m1_rdata      = '0;
        m0_err        = 1'b0;
        m1_err        = 1'b0;
        s_req_valid   = 1'b0;
        s_resp_ready  = 1'b0;
        if (rst) begin
            unique case (state_q)
                S_IDLE: begin
                    m0_req_ready = any_req & ~grant;
                    m1_req_ready = any_req & grant;
                end
                S_ADDR: begin
                    s_req_valid = 1'b1;
                end
                S_DATA: begin
                    s_resp_ready = owner_resp_ready;
                    if (owner_q) begin
                        m1_resp_valid = s_resp_valid;
                        m1_rdata      = rsp_data;
                    end else begin
                        m0_resp_valid = s_resp_valid;
                        m0_rdata      = rsp_data;
                    end
                end
                S_ERR: begin
                    if (owner_q) begin
                        m1_resp_valid = 1'b1;
                        m1_err        = 1'b1;
                    end else begin
                        m0_resp_valid = 1'b1;
                        m0_err        = 1'b1;
                    end
                end
                default: begin
                    s_req_valid = 1'b0;
                end
            endcase
        end
    end

    // Slave request fields come straight from the latch so they hold steady through ADDR.
    always_comb begin
        s_addr  = rst ? addr_q  : '0;
        s_wen   = rst ? wen_q   : 1'b0;
        s_wdata = rst ? wdata_q : '0;
        s_wmask = rst ? wmask_q : '0;
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
module tb_ysyx_24100005_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TO_W    = 8;
    localparam int TIMEOUT = 5;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;

    int checks = 0;
    int errors = 0;

    ysyx_24100005_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: is a transaction open, who owns it, has the slave taken
    // the request yet, how many cycles it has been with the slave, and has it been abandoned.
    bit          mb_busy, mb_sent, mb_err, mb_owner, mb_last;
    int          mb_age;
    logic [31:0] mb_addr, mb_wdata;
    logic        mb_wen;
    logic [3:0]  mb_wmask;

    logic        g, rr;
    logic        e_m0_rr, e_m1_rr, e_m0_rv, e_m1_rv, e_m0_err, e_m1_err, e_sreqv, e_srespr;
    logic [31:0] e_m0_rd, e_m1_rd, e_saddr, e_swdata;
    logic        e_swen;
    logic [3:0]  e_swmask;

    // Every cycle: predict all outputs from the model, compare, then advance the model.
    always @(negedge clk) begin
        g  = (m0_req_valid && m1_req_valid) ? !mb_last : m1_req_valid;
        rr = mb_owner ? m1_resp_ready : m0_resp_ready;
        {e_m0_rr, e_m1_rr, e_m0_rv, e_m1_rv, e_m0_err, e_m1_err, e_sreqv, e_srespr} = '0;
        e_m0_rd = '0; e_m1_rd = '0; e_saddr = '0; e_swdata = '0; e_swen = 1'b0; e_swmask = '0;
        if (rst) begin
            e_saddr = mb_addr; e_swen = mb_wen; e_swdata = mb_wdata; e_swmask = mb_wmask;
            if (!mb_busy) begin
                e_m0_rr = (m0_req_valid || m1_req_valid) && !g;
                e_m1_rr = (m0_req_valid || m1_req_valid) && g;
            end else if (mb_err) begin
                if (mb_owner) begin e_m1_rv = 1'b1; e_m1_err = 1'b1; end
                else          begin e_m0_rv = 1'b1; e_m0_err = 1'b1; end
            end else if (!mb_sent) begin
                e_sreqv = 1'b1;
            end else begin
                e_srespr = rr;
                if (mb_owner) begin e_m1_rv = s_resp_valid; e_m1_rd = mb_wen ? 32'h0 : s_rdata; end
                else          begin e_m0_rv = s_resp_valid; e_m0_rd = mb_wen ? 32'h0 : s_rdata; end
            end
        end
        check("cmp m0_req_ready", m0_req_ready, e_m0_rr);
        check("cmp m1_req_ready", m1_req_ready, e_m1_rr);
        check("cmp m0_resp_valid", m0_resp_valid, e_m0_rv);
        check("cmp m1_resp_valid", m1_resp_valid, e_m1_rv);
        check("cmp m0_rdata", m0_rdata, e_m0_rd);
        check("cmp m1_rdata", m1_rdata, e_m1_rd);
        check("cmp m0_err", m0_err, e_m0_err);
        check("cmp m1_err", m1_err, e_m1_err);
        check("cmp s_req_valid", s_req_valid, e_sreqv);
        check("cmp s_resp_ready", s_resp_ready, e_srespr);
        check("cmp s_addr", s_addr, e_saddr);
        check("cmp s_wen", s_wen, e_swen);
        check("cmp s_wdata", s_wdata, e_swdata);
        check("cmp s_wmask", s_wmask, e_swmask);

        if (!rst) begin
            mb_busy = 0; mb_sent = 0; mb_err = 0; mb_owner = 0; mb_last = 1; mb_age = 0;
            mb_addr = '0; mb_wen = 1'b0; mb_wdata = '0; mb_wmask = '0;
        end else if (!mb_busy) begin
            if (m0_req_valid || m1_req_valid) begin
                mb_busy = 1; mb_owner = g; mb_last = g; mb_age = 0; mb_sent = 0; mb_err = 0;
                mb_addr  = g ? m1_addr  : m0_addr;
                mb_wen   = g ? m1_wen   : m0_wen;
                mb_wdata = g ? m1_wdata : m0_wdata;
                mb_wmask = g ? m1_wmask : m0_wmask;
            end
        end else if (mb_err) begin
            if (rr) mb_busy = 0;
        end else begin
            if (mb_sent && s_resp_valid && rr) mb_busy = 0;
            else if (TIMEOUT != 0 && mb_age == TIMEOUT - 1) mb_err = 1;
            else if (!mb_sent && s_req_ready) mb_sent = 1;
            mb_age++;
        end
    end

    task automatic clear_inputs();
        m0_req_valid = 0; m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0; m0_resp_ready = 0;
        m1_req_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0; m1_resp_ready = 0;
        s_req_ready = 0; s_resp_valid = 0; s_rdata = '0;
    endtask

    // Advance to the input-drive point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Single m0 read.
        do_reset();
        m0_req_valid = 1; m0_addr = 32'h8000_0000; s_req_ready = 1;
        @(negedge clk);
        check("t1 m0_req_ready", m0_req_ready, 1);
        check("t1 m1_req_ready", m1_req_ready, 0);
        cyc(); m0_req_valid = 0;
        @(negedge clk);
        check("t1 s_req_valid", s_req_valid, 1);
        check("t1 s_addr", s_addr, 32'h8000_0000);
        cyc(); s_resp_valid = 1; s_rdata = 32'h0000_0513; m0_resp_ready = 1;
        @(negedge clk);
        check("t1 m0_resp_valid", m0_resp_valid, 1);
        check("t1 m0_rdata", m0_rdata, 32'h0000_0513);
        check("t1 m0_err", m0_err, 0);
        check("t1 m1_resp_valid", m1_resp_valid, 0);
        check("t1 m1_rdata", m1_rdata, 0);

        // Both masters continuously valid from reset: alternating grants.
        do_reset();
        m0_req_valid = 1; m0_addr = 32'h8000_0000;
        m1_req_valid = 1; m1_addr = 32'h8000_1000; m1_wen = 1; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
        s_req_ready = 1; s_resp_valid = 1; s_rdata = 32'h1111_2222;
        m0_resp_ready = 1; m1_resp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
                check("t2 m0 grant", m0_req_ready, ((c / 3) % 2 == 0));
                check("t2 m1 grant", m1_req_ready, ((c / 3) % 2 == 1));
            end else if (c % 3 == 1 && (c / 3) % 2 == 1) begin
                check("t2 s_wdata", s_wdata, 32'hDEAD_BEEF);
                check("t2 s_wmask", s_wmask, 4'hF);
                check("t2 s_addr", s_addr, 32'h8000_1000);
            end else if (c % 3 == 2) begin
                if ((c / 3) % 2 == 1) check("t2 m1 write rdata", m1_rdata, 0);
                else                  check("t2 m0 read rdata", m0_rdata, 32'h1111_2222);
            end
            cyc();
        end

        // Slave stalls the request for 3 cycles; response lands in the watchdog's last cycle.
        clear_inputs();
        m0_req_valid = 1; m0_wen = 1; m0_addr = 32'h8000_2004; m0_wdata = 32'h1234_5678; m0_wmask = 4'h5;
        @(negedge clk);
        check("t3 m0_req_ready", m0_req_ready, 1);
        cyc(); m0_req_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m1_req_valid = 1;
        for (int k = 0; k < 4; k++) begin
            s_req_ready = (k == 3);
            @(negedge clk);
            check("t3 s_req_valid", s_req_valid, 1);
            check("t3 s_addr stable", s_addr, 32'h8000_2004);
            check("t3 s_wdata stable", {s_wen, s_wmask, s_wdata}, {1'b1, 4'h5, 32'h1234_5678});
            check("t3 no second grant", m1_req_ready, 0);
            cyc();
        end
        s_req_ready = 0; s_resp_valid = 1; s_rdata = 32'hFFFF_FFFF; m0_resp_ready = 1; m1_req_valid = 0;
        @(negedge clk);
        check("t3 m0_resp_valid", m0_resp_valid, 1);
        check("t3 m0_err completion wins", m0_err, 0);
        check("t3 write rdata", m0_rdata, 0);
        cyc();

        // Owner holds off its response for 2 cycles.
        clear_inputs();
        m1_req_valid = 1; m1_addr = 32'h8000_3000; s_req_ready = 1;
        @(negedge clk);
        check("t4 m1_req_ready", m1_req_ready, 1);
        cyc(); m1_req_valid = 0;
        @(negedge clk);
        check("t4 s_req_valid", s_req_valid, 1);
        cyc(); s_resp_valid = 1; s_rdata = 32'hCAFE_0001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t4 s_resp_ready low", s_resp_ready, 0);
            check("t4 m1_resp_valid held", m1_resp_valid, 1);
            check("t4 m1_rdata held", m1_rdata, 32'hCAFE_0001);
            cyc();
        end
        m1_resp_ready = 1;
        @(negedge clk);
        check("t4 s_resp_ready", s_resp_ready, 1);
        check("t4 m1_resp_valid", m1_resp_valid, 1);
        cyc();
        @(negedge clk);
        check("t4 idle no forward", m1_resp_valid, 0);
        check("t4 idle s_resp_ready", s_resp_ready, 0);
        cyc();

        // Hung slave: watchdog error after 5 cycles, then m1 is served.
        clear_inputs();
        m0_req_valid = 1; m0_addr = 32'h8000_4000;
        @(negedge clk);
        check("t5 m0_req_ready", m0_req_ready, 1);
        cyc(); m0_req_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5 s_req_valid", s_req_valid, 1);
            check("t5 no early resp", m0_resp_valid, 0);
            cyc();
        end
        @(negedge clk);
        check("t5 err resp_valid", m0_resp_valid, 1);
        check("t5 err flag", m0_err, 1);
        check("t5 err rdata", m0_rdata, 0);
        check("t5 s_req_valid dropped", s_req_valid, 0);
        cyc(); m0_resp_ready = 1; s_resp_valid = 1; s_rdata = 32'h0000_0BAD;
        m1_req_valid = 1; m1_addr = 32'h8000_5000;
        @(negedge clk);
        check("t5 err held", m0_err, 1);
        check("t5 late s_resp_ready", s_resp_ready, 0);
        check("t5 m1 waits", m1_req_ready, 0);
        cyc();
        @(negedge clk);
        check("t5 m1 granted", m1_req_ready, 1);
        check("t5 late resp dropped", m0_resp_valid, 0);
        cyc(); m1_req_valid = 0; s_req_ready = 1; s_resp_valid = 0;
        @(negedge clk);
        check("t5 m1 s_addr", s_addr, 32'h8000_5000);
        cyc(); s_resp_valid = 1; s_rdata = 32'h0000_55AA; m1_resp_ready = 1;
        @(negedge clk);
        check("t5 m1 rdata", m1_rdata, 32'h0000_55AA);
        check("t5 m1 err", m1_err, 0);
        cyc();

        // Asynchronous reset in the middle of DATA.
        clear_inputs();
        m0_req_valid = 1; m0_addr = 32'h8000_6000; s_req_ready = 1;
        @(negedge clk);
        check("t6 m0_req_ready", m0_req_ready, 1);
        cyc(); m0_req_valid = 0;
        cyc(); s_resp_valid = 1; s_rdata = 32'h7777_0000; m0_req_valid = 1; m1_req_valid = 1;
        #1;
        check("t6 pre-reset resp", m0_resp_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("t6 rst m0_resp_valid", m0_resp_valid, 0);
        check("t6 rst req_ready", {m0_req_ready, m1_req_ready}, 2'b00);
        check("t6 rst s_req_valid", s_req_valid, 0);
        check("t6 rst s_addr", s_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6 tie to m0", {m0_req_ready, m1_req_ready}, 2'b10);
        cyc();

        // Randomised traffic checked by the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 399) != 0);
            m0_req_valid  = 1'($urandom_range(0, 1));
            m0_addr       = $urandom;
            m0_wen        = 1'($urandom_range(0, 1));
            m0_wdata      = $urandom;
            m0_wmask      = 4'($urandom);
            m0_resp_ready = ($urandom_range(0, 3) != 0);
            m1_req_valid  = 1'($urandom_range(0, 1));
            m1_addr       = $urandom;
            m1_wen        = 1'($urandom_range(0, 1));
            m1_wdata      = $urandom;
            m1_wmask      = 4'($urandom);
            m1_resp_ready = ($urandom_range(0, 3) != 0);
            s_req_ready   = 1'($urandom_range(0, 1));
            s_resp_valid  = ($urandom_range(0, 2) == 0);
            s_rdata       = $urandom;
            cyc();
        end
        rst = 1'b1;
        clear_inputs();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
